risc_toy_exec_unit: RTL and testbench



---
 rtl/risc_toy_exec_pkg.sv | 36 +++
 rtl/risc_toy_exec_unit_mul_iter.sv | 57 +++++
 rtl/risc_toy_exec_unit.sv | 175 +++++++++++++++++
 tb/tb_risc_toy_exec_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_toy_exec_pkg.sv
// RISC_TOY execute stage: shared opcodes, condition codes and FSM states.
// Imported by the execute unit and its iterative multiplier.
package risc_toy_exec_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_NEG    = 5'd2;
  localparam logic [4:0] OP_NOT    = 5'd3;
  localparam logic [4:0] OP_AND    = 5'd4;
  localparam logic [4:0] OP_OR     = 5'd5;
  localparam logic [4:0] OP_XOR    = 5'd6;
  localparam logic [4:0] OP_LSR    = 5'd7;
  localparam logic [4:0] OP_ASR    = 5'd8;
  localparam logic [4:0] OP_SHL    = 5'd9;
  localparam logic [4:0] OP_ROR    = 5'd10;
  localparam logic [4:0] OP_ADDI   = 5'd11;
  localparam logic [4:0] OP_ANDI   = 5'd12;
  localparam logic [4:0] OP_ORI    = 5'd13;
  localparam logic [4:0] OP_MOVI   = 5'd14;
  localparam logic [4:0] OP_AGEN   = 5'd15;
  localparam logic [4:0] OP_BRCOND = 5'd16;
  localparam logic [4:0] OP_MUL    = 5'd17;

  localparam logic [2:0] CC_NEVER  = 3'd0;
  localparam logic [2:0] CC_ALWAYS = 3'd1;
  localparam logic [2:0] CC_EQZ    = 3'd2;
  localparam logic [2:0] CC_NEZ    = 3'd3;
  localparam logic [2:0] CC_GEZ    = 3'd4;
  localparam logic [2:0] CC_LTZ    = 3'd5;

  typedef enum logic {
    S_IDLE,
    S_MUL_RUN
  } state_t;

endpackage

// File: rtl/risc_toy_exec_unit_mul_iter.sv
// Iterative shift-add multiplier, MUL_STEP multiplier bits per cycle.
// o_done is high during the final step; o_result is valid with it.
module risc_toy_mul_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_abort,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CYC = XLEN / MUL_STEP;
  localparam int CW  = $clog2(CYC + 1);

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] w_pp;
  logic [XLEN-1:0] w_sum;

  always_comb begin
    w_pp = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (r_mplier[i]) w_pp = w_pp + (r_mcand << i);
    end
  end

  assign w_sum    = r_acc + w_pp;
  assign o_done   = (r_cnt == CW'(1));
  assign o_result = w_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_cnt    <= CW'(CYC);
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_cnt != '0) begin
      r_cnt    <= r_cnt - CW'(1);
      r_mcand  <= r_mcand << MUL_STEP;
      r_mplier <= r_mplier >> MUL_STEP;
      r_acc    <= w_sum;
    end
  end

endmodule

// File: rtl/risc_toy_exec_unit.sv
// RISC_TOY execute stage: registered single-cycle ALU/branch ops plus
// an iterative MUL, with valid/ready on both sides and flush.
module risc_toy_exec_unit
  import risc_toy_exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IMM_W    = 17,
  parameter int TAG_W    = 5,
  parameter int MUL_STEP = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [4:0]       IN_OP,
  input  logic [XLEN-1:0]  IN_A,
  input  logic [XLEN-1:0]  IN_B,
  input  logic [IMM_W-1:0] IN_IMM,
  input  logic [2:0]       IN_COND,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  OUT_RESULT,
  output logic             OUT_TAKEN,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             BUSY
);

  localparam int SHW  = $clog2(XLEN);
  localparam int SHW1 = SHW + 1;
  localparam logic [SHW:0] W_XLEN = SHW1'(XLEN);

  state_t r_state;
  state_t w_state_nxt;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_result;
  logic             r_out_taken;
  logic [TAG_W-1:0] r_out_tag;
  logic [TAG_W-1:0] r_mul_tag;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [XLEN-1:0]  w_mul_res;
  logic [XLEN-1:0]  w_imm;
  logic [SHW-1:0]   w_sh;
  logic [SHW:0]     w_rsh;
  logic             w_cond;
  logic [XLEN-1:0]  w_alu_res;
  logic             w_alu_taken;

  assign IN_READY   = (r_state == S_IDLE) && !FLUSH
                   && (!r_out_valid || OUT_READY);
  assign w_in_fire  = IN_VALID && IN_READY;
  assign w_out_fire = r_out_valid && OUT_READY;
  assign w_is_mul   = (IN_OP == OP_MUL);
  assign w_mul_start = w_in_fire && w_is_mul;

  assign OUT_VALID  = r_out_valid;
  assign OUT_RESULT = r_out_result;
  assign OUT_TAKEN  = r_out_taken;
  assign OUT_TAG    = r_out_tag;
  assign BUSY       = (r_state == S_MUL_RUN);

  if (XLEN > IMM_W) begin : g_sext
    assign w_imm = {{(XLEN-IMM_W){IN_IMM[IMM_W-1]}}, IN_IMM};
  end else begin : g_trunc
    assign w_imm = IN_IMM[XLEN-1:0];
  end

  assign w_sh  = IN_B[SHW-1:0];
  // Left shift by XLEN clears, so sh=0 rotates to A itself.
  assign w_rsh = W_XLEN - {1'b0, w_sh};

  always_comb begin
    w_cond = 1'b0;
    case (IN_COND)
      CC_ALWAYS: w_cond = 1'b1;
      CC_EQZ:    w_cond = (IN_B == '0);
      CC_NEZ:    w_cond = (IN_B != '0);
      CC_GEZ:    w_cond = !IN_B[XLEN-1];
      CC_LTZ:    w_cond = IN_B[XLEN-1];
      default:   w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_res   = '0;
    w_alu_taken = 1'b0;
    case (IN_OP)
      OP_ADD:  w_alu_res = IN_A + IN_B;
      OP_SUB:  w_alu_res = IN_A - IN_B;
      OP_NEG:  w_alu_res = -IN_B;
      OP_NOT:  w_alu_res = ~IN_B;
      OP_AND:  w_alu_res = IN_A & IN_B;
      OP_OR:   w_alu_res = IN_A | IN_B;
      OP_XOR:  w_alu_res = IN_A ^ IN_B;
      OP_LSR:  w_alu_res = IN_A >> w_sh;
      OP_ASR:  w_alu_res = $unsigned($signed(IN_A) >>> w_sh);
      OP_SHL:  w_alu_res = IN_A << w_sh;
      OP_ROR:  w_alu_res = (IN_A >> w_sh) | (IN_A << w_rsh);
      OP_ADDI: w_alu_res = IN_A + w_imm;
      OP_ANDI: w_alu_res = IN_A & w_imm;
      OP_ORI:  w_alu_res = IN_A | w_imm;
      OP_MOVI: w_alu_res = w_imm;
      OP_AGEN: w_alu_res = IN_A + w_imm;
      OP_BRCOND: begin
        w_alu_res   = IN_A;
        w_alu_taken = w_cond;
      end
      default: w_alu_res = '0;
    endcase
  end

  risc_toy_mul_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_abort  (FLUSH),
    .i_start  (w_mul_start),
    .i_a      (IN_A),
    .i_b      (IN_B),
    .o_done   (w_mul_done),
    .o_result (w_mul_res)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_mul_start) w_state_nxt = S_MUL_RUN;
      S_MUL_RUN: if (w_mul_done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (FLUSH) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_taken  <= 1'b0;
      r_out_tag    <= '0;
      r_mul_tag    <= '0;
    end else if (FLUSH) begin
      r_out_valid <= 1'b0;
    end else begin
      if (w_out_fire) r_out_valid <= 1'b0;
      if (w_in_fire && !w_is_mul) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_alu_res;
        r_out_taken  <= w_alu_taken;
        r_out_tag    <= IN_TAG;
      end
      if (w_mul_start) r_mul_tag <= IN_TAG;
      if (BUSY && w_mul_done) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_mul_res;
        r_out_taken  <= 1'b0;
        r_out_tag    <= r_mul_tag;
      end
    end
  end

endmodule

// File: tb/tb_risc_toy_exec_unit.sv
// Bench for risc_toy_exec_unit: scoreboard model plus directed vectors,
// backpressure, flush and reset-mid-MUL scenarios, and a MUL_STEP=4 instance.
module tb_risc_toy_exec_unit;
  import risc_toy_exec_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [4:0]  IN_OP, IN_TAG, OUT_TAG;
  logic [31:0] IN_A, IN_B, OUT_RESULT;
  logic [16:0] IN_IMM;
  logic [2:0]  IN_COND;
  logic        OUT_TAKEN, BUSY;

  logic        FLUSH4, IN_VALID4, IN_READY4, OUT_VALID4, OUT_READY4;
  logic [4:0]  IN_OP4, IN_TAG4, OUT_TAG4;
  logic [31:0] IN_A4, IN_B4, OUT_RESULT4;
  logic [16:0] IN_IMM4;
  logic [2:0]  IN_COND4;
  logic        OUT_TAKEN4, BUSY4;

  risc_toy_exec_unit #(.XLEN(32), .IMM_W(17), .TAG_W(5), .MUL_STEP(1)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP),
    .IN_A(IN_A), .IN_B(IN_B), .IN_IMM(IN_IMM), .IN_COND(IN_COND),
    .IN_TAG(IN_TAG), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_RESULT(OUT_RESULT), .OUT_TAKEN(OUT_TAKEN), .OUT_TAG(OUT_TAG),
    .BUSY(BUSY)
  );

  risc_toy_exec_unit #(.XLEN(32), .IMM_W(17), .TAG_W(5), .MUL_STEP(4)) dut4 (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH4),
    .IN_VALID(IN_VALID4), .IN_READY(IN_READY4), .IN_OP(IN_OP4),
    .IN_A(IN_A4), .IN_B(IN_B4), .IN_IMM(IN_IMM4), .IN_COND(IN_COND4),
    .IN_TAG(IN_TAG4), .OUT_VALID(OUT_VALID4), .OUT_READY(OUT_READY4),
    .OUT_RESULT(OUT_RESULT4), .OUT_TAKEN(OUT_TAKEN4), .OUT_TAG(OUT_TAG4),
    .BUSY(BUSY4)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural model: {taken, result}
  function automatic logic [32:0] model(input logic [4:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [16:0] imm, input logic [2:0] cc);
    logic [31:0] r, im;
    logic        t;
    logic [63:0] p;
    int          sh, sb, ia;
    r  = 32'h0;
    t  = 1'b0;
    sh = int'(b[4:0]);
    sb = int'(b);
    ia = int'(a);
    im = imm[16] ? (32'(imm) - 32'h0002_0000) : 32'(imm);
    p  = {32'h0, a} * {32'h0, b};
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_NEG:  r = 32'h0 - b;
      OP_NOT:  r = ~b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_LSR:  r = a >> sh;
      OP_ASR:  r = 32'(ia >>> sh);
      OP_SHL:  r = a << sh;
      OP_ROR:  r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
      OP_ADDI, OP_AGEN: r = a + im;
      OP_ANDI: r = a & im;
      OP_ORI:  r = a | im;
      OP_MOVI: r = im;
      OP_BRCOND: begin
        r = a;
        case (cc)
          3'd1: t = 1'b1;
          3'd2: t = (sb == 0);
          3'd3: t = (sb != 0);
          3'd4: t = (sb >= 0);
          3'd5: t = (sb < 0);
          default: t = 1'b0;
        endcase
      end
      OP_MUL:  r = p[31:0];
      default: r = 32'h0;
    endcase
    return {t, r};
  endfunction

  typedef struct packed {
    logic [31:0] res;
    logic        tk;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_recv = 0;
  logic [32:0] m_v;

  always @(posedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY) begin
      if (q.size() > 0) void'(q.pop_front());
      n_recv++;
    end
    if (RST || FLUSH) begin
      q.delete();
    end else if (IN_VALID && IN_READY) begin
      m_v = model(IN_OP, IN_A, IN_B, IN_IMM, IN_COND);
      q.push_back({m_v[31:0], m_v[32], IN_TAG});
    end
  end

  always @(negedge CLK) begin
    if (!RST && OUT_VALID) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_spurious: OUT_VALID=1 tag %h with no pending op",
                 OUT_TAG);
      end else begin
        check("sb_result", OUT_RESULT, q[0].res);
        check("sb_taken", 32'(OUT_TAKEN), 32'(q[0].tk));
        check("sb_tag", 32'(OUT_TAG), 32'(q[0].tag));
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] a,
      input logic [31:0] b, input logic [16:0] imm,
      input logic [2:0] cc, input logic [4:0] tag);
    int   n;
    logic r;
    IN_VALID = 1'b1;
    IN_OP = op; IN_A = a; IN_B = b;
    IN_IMM = imm; IN_COND = cc; IN_TAG = tag;
    n = 0;
    do begin
      @(negedge CLK);
      r = IN_READY;
      @(posedge CLK);
      #1;
      n++;
    end while (!r && n < 100);
    IN_VALID = 1'b0;
    check("send_accept", 32'(r), 32'd1);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    @(negedge CLK);
    while (!OUT_VALID && cyc < 60) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [16:0] imm;
    logic [2:0]  cc;
    logic [31:0] er;
    logic        et;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV] = '{
    '{OP_ADD,    32'h7FFF_FFFF, 32'h1,         17'h0,     3'd0, 32'h8000_0000, 1'b0},
    '{OP_ADDI,   32'h5,         32'h0,         17'h1FFFF, 3'd0, 32'h0000_0004, 1'b0},
    '{OP_ROR,    32'h8000_0001, 32'h0,         17'h0,     3'd0, 32'h8000_0001, 1'b0},
    '{OP_ROR,    32'h8000_0001, 32'h1,         17'h0,     3'd0, 32'hC000_0000, 1'b0},
    '{OP_ASR,    32'h8000_0000, 32'd31,        17'h0,     3'd0, 32'hFFFF_FFFF, 1'b0},
    '{OP_LSR,    32'h8000_0000, 32'd31,        17'h0,     3'd0, 32'h0000_0001, 1'b0},
    '{OP_BRCOND, 32'h100,       32'hFFFF_FFFF, 17'h0,     3'd5, 32'h0000_0100, 1'b1},
    '{OP_BRCOND, 32'h55,        32'h0,         17'h0,     3'd4, 32'h0000_0055, 1'b1},
    '{OP_BRCOND, 32'h66,        32'h1,         17'h0,     3'd2, 32'h0000_0066, 1'b0},
    '{OP_BRCOND, 32'h77,        32'h0,         17'h0,     3'd7, 32'h0000_0077, 1'b0},
    '{OP_BRCOND, 32'h88,        32'h0,         17'h0,     3'd2, 32'h0000_0088, 1'b1},
    '{OP_BRCOND, 32'h99,        32'h5,         17'h0,     3'd0, 32'h0000_0099, 1'b0},
    '{OP_SUB,    32'h5,         32'h7,         17'h0,     3'd0, 32'hFFFF_FFFE, 1'b0},
    '{OP_NEG,    32'h123,       32'h1,         17'h0,     3'd0, 32'hFFFF_FFFF, 1'b0},
    '{OP_NOT,    32'h0,         32'h0F0F_0F0F, 17'h0,     3'd0, 32'hF0F0_F0F0, 1'b0},
    '{OP_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 17'h0,     3'd0, 32'hF000_F000, 1'b0},
    '{OP_OR,     32'hF0F0_F0F0, 32'hFF00_FF00, 17'h0,     3'd0, 32'hFFF0_FFF0, 1'b0},
    '{OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 17'h0,     3'd0, 32'h0FF0_0FF0, 1'b0},
    '{OP_SHL,    32'h1,         32'h21,        17'h0,     3'd0, 32'h0000_0002, 1'b0},
    '{OP_ANDI,   32'hFFFF_FFFF, 32'h0,         17'h000F0, 3'd0, 32'h0000_00F0, 1'b0},
    '{OP_ORI,    32'h100,       32'h0,         17'h10000, 3'd0, 32'hFFFF_0100, 1'b0},
    '{OP_MOVI,   32'hDEAD,      32'h0,         17'h01234, 3'd0, 32'h0000_1234, 1'b0},
    '{OP_AGEN,   32'h1000,      32'h0,         17'h1FFF0, 3'd0, 32'h0000_0FF0, 1'b0},
    '{5'd31,     32'h5,         32'h5,         17'h5,     3'd1, 32'h0000_0000, 1'b0},
    '{OP_MUL,    32'h3,         32'h5,         17'h0,     3'd0, 32'h0000_000F, 1'b0},
    '{OP_ASR,    32'h4000_0000, 32'd4,         17'h0,     3'd0, 32'h0400_0000, 1'b0},
    '{OP_BRCOND, 32'h1,         32'h8000_0000, 17'h0,     3'd3, 32'h0000_0001, 1'b1}
  };

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, idx, bad, base, vcnt;
    logic r;
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    IN_OP = '0; IN_A = '0; IN_B = '0; IN_IMM = '0; IN_COND = '0; IN_TAG = '0;
    FLUSH4 = 1'b0; IN_VALID4 = 1'b0; OUT_READY4 = 1'b1;
    IN_OP4 = '0; IN_A4 = '0; IN_B4 = '0; IN_IMM4 = '0; IN_COND4 = '0;
    IN_TAG4 = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_result", OUT_RESULT, 32'd0);
    check("rst_taken", 32'(OUT_TAKEN), 32'd0);
    check("rst_tag", 32'(OUT_TAG), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'd1);

    for (int i = 0; i < NV; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].cc, 5'(i));
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat),
            (vt[i].op == OP_MUL) ? 32'd32 : 32'd0);
      check($sformatf("vec%0d_result", i), OUT_RESULT, vt[i].er);
      check($sformatf("vec%0d_taken", i), 32'(OUT_TAKEN), 32'(vt[i].et));
      check($sformatf("vec%0d_tag", i), 32'(OUT_TAG), i);
    end

    // Long MUL: busy and not ready for all 32 iterations
    send(OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 17'h0, 3'd0, 5'd7);
    bad = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge CLK);
      if (!BUSY || IN_READY || OUT_VALID) bad++;
    end
    check("mul_busy_window_bad_cycles", 32'(bad), 32'd0);
    @(negedge CLK);
    check("mul_valid", 32'(OUT_VALID), 32'd1);
    check("mul_result", OUT_RESULT, 32'hFFFE_0001);
    check("mul_tag", 32'(OUT_TAG), 32'd7);
    check("mul_busy_done", 32'(BUSY), 32'd0);

    // Backpressure: 4 ADDs, OUT_READY low for 3 cycles mid-stream
    @(posedge CLK);
    #1;
    base = n_recv;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      OUT_READY = !(c >= 3 && c <= 5);
      if (idx < 4) begin
        IN_VALID = 1'b1; IN_OP = OP_ADD;
        IN_A = 32'h1000 * (idx + 1); IN_B = 32'(idx);
        IN_IMM = '0; IN_COND = '0; IN_TAG = 5'(10 + idx);
      end else begin
        IN_VALID = 1'b0;
      end
      @(negedge CLK);
      r = IN_READY;
      if (OUT_VALID && !OUT_READY) check("bp_in_ready_low", 32'(IN_READY), 32'd0);
      @(posedge CLK);
      #1;
      if (IN_VALID && r) idx++;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("bp_all_accepted", 32'(idx), 32'd4);
    check("bp_all_delivered", 32'(n_recv - base), 32'd4);
    check("bp_queue_empty", 32'(q.size()), 32'd0);

    // Flush a stalled pending result
    OUT_READY = 1'b0;
    send(OP_BRCOND, 32'h0000_ABCD, 32'h0, 17'h0, 3'd1, 5'd21);
    @(negedge CLK);
    check("fl_pending_valid", 32'(OUT_VALID), 32'd1);
    FLUSH = 1'b1;
    @(posedge CLK);
    #1 FLUSH = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("fl_pending_cleared", 32'(OUT_VALID), 32'd0);

    // Flush on MUL cycle 10
    send(OP_MUL, 32'h1234, 32'h10, 17'h0, 3'd0, 5'd3);
    repeat (9) @(posedge CLK);
    #1 FLUSH = 1'b1;
    @(negedge CLK);
    check("flm_busy_c10", 32'(BUSY), 32'd1);
    check("flm_in_ready_during", 32'(IN_READY), 32'd0);
    @(posedge CLK);
    #1 FLUSH = 1'b0;
    @(negedge CLK);
    check("flm_valid_after", 32'(OUT_VALID), 32'd0);
    check("flm_busy_after", 32'(BUSY), 32'd0);
    check("flm_in_ready_after", 32'(IN_READY), 32'd1);
    vcnt = 0;
    repeat (40) begin
      @(negedge CLK);
      if (OUT_VALID) vcnt++;
    end
    check("flm_no_result", 32'(vcnt), 32'd0);

    // Reset mid-MUL
    send(OP_MUL, 32'h55, 32'h3, 17'h0, 3'd0, 5'd9);
    repeat (5) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rmm_out_valid", 32'(OUT_VALID), 32'd0);
    check("rmm_result", OUT_RESULT, 32'd0);
    check("rmm_taken", 32'(OUT_TAKEN), 32'd0);
    check("rmm_tag", 32'(OUT_TAG), 32'd0);
    check("rmm_busy", 32'(BUSY), 32'd0);
    check("rmm_in_ready", 32'(IN_READY), 32'd1);
    vcnt = 0;
    repeat (40) begin
      @(negedge CLK);
      if (OUT_VALID) vcnt++;
    end
    check("rmm_no_result", 32'(vcnt), 32'd0);

    // MUL_STEP=4 instance: latency 8
    @(posedge CLK);
    #1;
    IN_VALID4 = 1'b1; IN_OP4 = OP_MUL; IN_A4 = 32'h0000_FFFF;
    IN_B4 = 32'h0000_FFFF; IN_TAG4 = 5'd9;
    @(negedge CLK);
    check("m4_in_ready", 32'(IN_READY4), 32'd1);
    @(posedge CLK);
    #1 IN_VALID4 = 1'b0;
    lat = 0;
    @(negedge CLK);
    while (!OUT_VALID4 && lat < 60) begin
      if (!BUSY4) bad++;
      @(negedge CLK);
      lat++;
    end
    check("m4_latency", 32'(lat), 32'd8);
    check("m4_result", OUT_RESULT4, 32'hFFFE_0001);
    check("m4_tag", 32'(OUT_TAG4), 32'd9);
    check("m4_taken", 32'(OUT_TAKEN4), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
